// File: rtl/dca_matrix_lsu_txn_scheduler.sv
// rtl/dca_matrix_lsu_txn_scheduler.sv - matrix LSU instruction to AXI burst transaction sequencer
// Optional feature macro: DCA_MATRIX_LSU_TXN_4KB_SPLIT_EN (bursts never cross a 4KB page).
// Ports:
//   clk, rstnn                       clock, asynchronous active-low reset
//   inst_valid/inst_ready            instruction handshake (accepted only when idle)
//   inst_addr/stride/num_row_m1/num_col_m1  matrix geometry
//   txn_valid/txn_ready              transaction handshake
//   txn_bitaddr/txn_alen/txn_last    transaction bit address, beats-1, final flag
//   busy, done                       activity level, one-cycle completion pulse
module dca_matrix_lsu_txn_scheduler #(
  parameter int BW_AXI_ADDR   = 32,
  parameter int BW_AXI_DATA   = 32,
  parameter int BW_STRIDE     = 16,
  parameter int BW_NUM_ROW    = 8,
  parameter int BW_NUM_COL    = 12,
  parameter int MAX_BURST_LEN = 16
) (
  input  logic                   clk,
  input  logic                   rstnn,
  input  logic                   inst_valid,
  output logic                   inst_ready,
  input  logic [BW_AXI_ADDR-1:0] inst_addr,
  input  logic [BW_STRIDE-1:0]   inst_stride,
  input  logic [BW_NUM_ROW-1:0]  inst_num_row_m1,
  input  logic [BW_NUM_COL-1:0]  inst_num_col_m1,
  output logic                   txn_valid,
  input  logic                   txn_ready,
  output logic [BW_AXI_ADDR+2:0] txn_bitaddr,
  output logic [7:0]             txn_alen,
  output logic                   txn_last,
  output logic                   busy,
  output logic                   done
);

  localparam int BEAT_BYTES = BW_AXI_DATA / 8;
  localparam int LOG2_BB    = $clog2(BEAT_BYTES);
  // Wide enough for a full row count and for a 4KB page room in beats.
  localparam int BW_REM     = (BW_NUM_COL + 1 > 13) ? BW_NUM_COL + 1 : 13;
  localparam logic [BW_REM-1:0] MAX_BL = BW_REM'(MAX_BURST_LEN);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_ISSUE = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]             state_q,      state_d;
  logic [BW_AXI_ADDR-1:0] row_base_q,   row_base_d;
  logic [BW_AXI_ADDR-1:0] cur_addr_q,   cur_addr_d;
  logic [BW_STRIDE-1:0]   stride_q,     stride_d;
  logic [BW_NUM_ROW-1:0]  num_row_m1_q, num_row_m1_d;
  logic [BW_NUM_COL-1:0]  num_col_m1_q, num_col_m1_d;
  logic [BW_NUM_ROW-1:0]  row_cnt_q,    row_cnt_d;
  logic [BW_REM-1:0]      col_rem_q,    col_rem_d;

  logic [BW_REM-1:0]      beats;
  logic                   issue;
  logic                   row_end;
  logic                   row_last;
  logic [BW_AXI_ADDR-1:0] next_row_base;
`ifdef DCA_MATRIX_LSU_TXN_4KB_SPLIT_EN
  logic [12:0]            page_room;
`endif

  always_comb begin
    beats = (col_rem_q < MAX_BL) ? col_rem_q : MAX_BL;
`ifdef DCA_MATRIX_LSU_TXN_4KB_SPLIT_EN
    // Beats left before the next 4KB boundary; never zero since addresses are beat aligned.
    page_room = (13'h1000 - {1'b0, cur_addr_q[11:0]}) >> LOG2_BB;
    if (BW_REM'(page_room) < beats) begin
      beats = BW_REM'(page_room);
    end
`endif
  end

  assign issue         = (state_q == S_ISSUE);
  assign row_end       = (beats == col_rem_q);
  assign row_last      = (row_cnt_q == num_row_m1_q);
  assign next_row_base = row_base_q + BW_AXI_ADDR'(stride_q);

  // Transaction fields are gated so idle/done cycles present zeros.
  assign inst_ready  = (state_q == S_IDLE);
  assign busy        = (state_q != S_IDLE);
  assign done        = (state_q == S_DONE);
  assign txn_valid   = issue;
  assign txn_bitaddr = issue ? {cur_addr_q, 3'b000} : '0;
  assign txn_alen    = issue ? (beats[7:0] - 8'd1) : 8'd0;
  assign txn_last    = issue & row_last & row_end;

  always_comb begin
    state_d      = state_q;
    row_base_d   = row_base_q;
    cur_addr_d   = cur_addr_q;
    stride_d     = stride_q;
    num_row_m1_d = num_row_m1_q;
    num_col_m1_d = num_col_m1_q;
    row_cnt_d    = row_cnt_q;
    col_rem_d    = col_rem_q;
    case (state_q)
      S_IDLE: begin
        if (inst_valid) begin
          row_base_d   = inst_addr & ~BW_AXI_ADDR'(BEAT_BYTES - 1);
          cur_addr_d   = inst_addr & ~BW_AXI_ADDR'(BEAT_BYTES - 1);
          stride_d     = inst_stride;
          num_row_m1_d = inst_num_row_m1;
          num_col_m1_d = inst_num_col_m1;
          row_cnt_d    = '0;
          col_rem_d    = BW_REM'(inst_num_col_m1) + BW_REM'(1);
          state_d      = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (txn_ready) begin
          if (!row_end) begin
            col_rem_d  = col_rem_q - beats;
            cur_addr_d = cur_addr_q + (BW_AXI_ADDR'(beats) << LOG2_BB);
          end else if (!row_last) begin
            row_base_d = next_row_base;
            cur_addr_d = next_row_base;
            col_rem_d  = BW_REM'(num_col_m1_q) + BW_REM'(1);
            row_cnt_d  = row_cnt_q + BW_NUM_ROW'(1);
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstnn) begin
    if (!rstnn) begin
      state_q      <= S_IDLE;
      row_base_q   <= '0;
      cur_addr_q   <= '0;
      stride_q     <= '0;
      num_row_m1_q <= '0;
      num_col_m1_q <= '0;
      row_cnt_q    <= '0;
      col_rem_q    <= '0;
    end else begin
      state_q      <= state_d;
      row_base_q   <= row_base_d;
      cur_addr_q   <= cur_addr_d;
      stride_q     <= stride_d;
      num_row_m1_q <= num_row_m1_d;
      num_col_m1_q <= num_col_m1_d;
      row_cnt_q    <= row_cnt_d;
      col_rem_q    <= col_rem_d;
    end
  end

endmodule

// File: tb/tb_dca_matrix_lsu_txn_scheduler.sv
// tb/tb_dca_matrix_lsu_txn_scheduler.sv - self-checking bench for dca_matrix_lsu_txn_scheduler
module tb_dca_matrix_lsu_txn_scheduler;

  localparam int MAXB = 16;
  localparam int BB   = 4;

  logic        clk = 1'b0;
  logic        rstnn = 1'b0;
  logic        inst_valid = 1'b0;
  logic        inst_ready;
  logic [31:0] inst_addr = '0;
  logic [15:0] inst_stride = '0;
  logic [7:0]  inst_num_row_m1 = '0;
  logic [11:0] inst_num_col_m1 = '0;
  logic        txn_valid;
  logic        txn_ready = 1'b0;
  logic [34:0] txn_bitaddr;
  logic [7:0]  txn_alen;
  logic        txn_last;
  logic        busy;
  logic        done;

  always #5 clk = ~clk;

  dca_matrix_lsu_txn_scheduler dut (
    .clk(clk), .rstnn(rstnn),
    .inst_valid(inst_valid), .inst_ready(inst_ready),
    .inst_addr(inst_addr), .inst_stride(inst_stride),
    .inst_num_row_m1(inst_num_row_m1), .inst_num_col_m1(inst_num_col_m1),
    .txn_valid(txn_valid), .txn_ready(txn_ready),
    .txn_bitaddr(txn_bitaddr), .txn_alen(txn_alen), .txn_last(txn_last),
    .busy(busy), .done(done)
  );

  typedef struct packed {
    logic [34:0] bitaddr;
    logic [7:0]  alen;
    logic        last;
  } txn_t;

  typedef struct {
    logic [31:0] addr;
    logic [15:0] stride;
    logic [7:0]  nr;
    logic [11:0] nc;
    int          pct;
    int          exp_n;
    logic [34:0] exp_first_ba;
    logic [7:0]  exp_first_alen;
    logic [34:0] exp_last_ba;
    logic [7:0]  exp_last_alen;
  } vec_t;

  txn_t got[$];
  txn_t exp_q[$];
  vec_t vt[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end
  endtask

  // Reference: walk rows and split each into bursts from the geometry rules.
  function automatic void build_model(input logic [31:0] addr, input logic [15:0] stride,
                                      input logic [7:0] nr, input logic [11:0] nc);
    logic [31:0] rb;
    logic [31:0] a;
    int          rem;
    int          b;
    txn_t        t;
    exp_q.delete();
    rb = addr & ~32'(BB - 1);
    for (int r = 0; r <= int'(nr); r++) begin
      a   = rb;
      rem = int'(nc) + 1;
      while (rem > 0) begin
        b = (rem < MAXB) ? rem : MAXB;
`ifdef DCA_MATRIX_LSU_TXN_4KB_SPLIT_EN
        if ((4096 - int'(a[11:0])) / BB < b) b = (4096 - int'(a[11:0])) / BB;
`endif
        t.bitaddr = {a, 3'b000};
        t.alen    = 8'(b - 1);
        t.last    = (r == int'(nr)) && (rem == b);
        exp_q.push_back(t);
        a   = a + 32'(b * BB);
        rem = rem - b;
      end
      rb = rb + 32'(stride);
    end
  endfunction

  task automatic run_inst(input logic [31:0] addr, input logic [15:0] stride,
                          input logic [7:0] nr, input logic [11:0] nc,
                          input int pct, input string tag);
    txn_t held;
    txn_t cur;
    bit   stalled = 1'b0;
    bit   seen_last = 1'b0;
    int   cyc = 0;
    got.delete();
    held = '0;
    build_model(addr, stride, nr, nc);
    check({tag, " inst_ready idle"}, 64'(inst_ready), 64'd1);
    inst_addr = addr; inst_stride = stride;
    inst_num_row_m1 = nr; inst_num_col_m1 = nc;
    inst_valid = 1'b1;
    @(posedge clk); #1;
    inst_valid = 1'b0;
    check({tag, " first txn latency"}, 64'(txn_valid), 64'd1);
    while (!seen_last && cyc < 4000) begin
      txn_ready = ($urandom_range(99) < pct);
      @(negedge clk);
      cur = '{txn_bitaddr, txn_alen, txn_last};
      if (stalled) begin
        check({tag, " stall valid"}, 64'(txn_valid), 64'd1);
        check({tag, " stall fields"}, 64'(cur), 64'(held));
      end
      if (txn_valid && txn_ready) begin
        got.push_back(cur);
        if (txn_last) seen_last = 1'b1;
      end
      stalled = txn_valid && !txn_ready;
      held    = cur;
      @(posedge clk); #1;
      cyc++;
    end
    txn_ready = 1'b0;
    if (!seen_last) begin
      n_tests++; n_fail++;
      $display("FAIL %s timeout: got %0d txns, expected %0d", tag, got.size(), exp_q.size());
    end else begin
      check({tag, " done pulse"}, 64'(done), 64'd1);
      check({tag, " done inst_ready"}, 64'(inst_ready), 64'd0);
      check({tag, " done txn_valid"}, 64'(txn_valid), 64'd0);
      @(posedge clk); #1;
      check({tag, " done width"}, 64'(done), 64'd0);
      check({tag, " idle again"}, 64'({inst_ready, busy}), 64'b10);
    end
    check({tag, " txn count"}, 64'(got.size()), 64'(exp_q.size()));
    for (int i = 0; i < got.size() && i < exp_q.size(); i++)
      check($sformatf("%s txn%0d", tag, i), 64'(got[i]), 64'(exp_q[i]));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got 0 expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset values.
    repeat (2) @(posedge clk);
    #1;
    check("reset inst_ready", 64'(inst_ready), 64'd1);
    check("reset outputs", 64'({txn_valid, txn_last, busy, done, txn_alen, txn_bitaddr}), 64'd0);
    @(negedge clk); rstnn = 1'b1;
    @(posedge clk); #1;

    // Directed table: {inputs, expected count / first / last transaction}.
    vt.push_back('{32'h1000, 16'h0, 8'd0, 12'd3, 100, 1, 35'h8000, 8'd3, 35'h8000, 8'd3});
    vt.push_back('{32'h2000, 16'h100, 8'd2, 12'd19, 100, 6, 35'h10000, 8'd15, 35'h11200, 8'd3});
    vt.push_back('{32'h2000, 16'h100, 8'd2, 12'd19, 40, 6, 35'h10000, 8'd15, 35'h11200, 8'd3});
`ifdef DCA_MATRIX_LSU_TXN_4KB_SPLIT_EN
    vt.push_back('{32'h0FF8, 16'h0, 8'd0, 12'd7, 100, 2, 35'h7FC0, 8'd1, 35'h8000, 8'd5});
`else
    vt.push_back('{32'h0FF8, 16'h0, 8'd0, 12'd7, 100, 1, 35'h7FC0, 8'd7, 35'h7FC0, 8'd7});
`endif
    vt.push_back('{32'h40, 16'h0, 8'd2, 12'd0, 70, 3, 35'h200, 8'd0, 35'h200, 8'd0});
    vt.push_back('{32'hFFFFFFC0, 16'h80, 8'd1, 12'd3, 100, 2, 35'h7FFFFFE00, 8'd3, 35'h200, 8'd3});
    vt.push_back('{32'h1003, 16'h0, 8'd0, 12'd1, 100, 1, 35'h8000, 8'd1, 35'h8000, 8'd1});
    vt.push_back('{32'h3000, 16'h0, 8'd0, 12'd15, 100, 1, 35'h18000, 8'd15, 35'h18000, 8'd15});
    vt.push_back('{32'h3000, 16'h0, 8'd0, 12'd16, 100, 2, 35'h18000, 8'd15, 35'h18200, 8'd0});

    for (int v = 0; v < vt.size(); v++) begin
      string tag;
      tag = $sformatf("vec%0d", v);
      run_inst(vt[v].addr, vt[v].stride, vt[v].nr, vt[v].nc, vt[v].pct, tag);
      check({tag, " table count"}, 64'(got.size()), 64'(vt[v].exp_n));
      if (got.size() > 0) begin
        check({tag, " table first"}, 64'({got[0].bitaddr, got[0].alen}),
              64'({vt[v].exp_first_ba, vt[v].exp_first_alen}));
        check({tag, " table last"}, 64'({got[$].bitaddr, got[$].alen, got[$].last}),
              64'({vt[v].exp_last_ba, vt[v].exp_last_alen, 1'b1}));
      end
    end

    // inst_valid held high through an operation.
    inst_addr = 32'h3000; inst_stride = '0; inst_num_row_m1 = '0; inst_num_col_m1 = 12'd3;
    inst_valid = 1'b1; txn_ready = 1'b1;
    @(posedge clk); #1;
    inst_addr = 32'h5000;
    check("hold issue A", 64'({txn_valid, inst_ready, txn_bitaddr}), 64'({2'b10, 35'h18000}));
    @(posedge clk); #1;
    check("hold done A", 64'({done, inst_ready}), 64'b10);
    @(posedge clk); #1;
    check("hold idle", 64'({inst_ready, txn_valid, done}), 64'b100);
    @(posedge clk); #1;
    inst_valid = 1'b0;
    check("hold issue B", 64'({txn_valid, txn_bitaddr}), 64'({1'b1, 35'h28000}));
    @(posedge clk); #1;
    check("hold done B", 64'(done), 64'd1);
    txn_ready = 1'b0;
    @(posedge clk); #1;

    // Asynchronous reset during the second transaction.
    inst_addr = 32'h2000; inst_stride = 16'h100; inst_num_row_m1 = 8'd1; inst_num_col_m1 = 12'd19;
    inst_valid = 1'b1;
    @(posedge clk); #1;
    inst_valid = 1'b0; txn_ready = 1'b1;
    @(posedge clk); #1;
    check("rst second txn", 64'({txn_valid, txn_bitaddr}), 64'({1'b1, 35'h10200}));
    #2 rstnn = 1'b0;
    #1;
    check("rst async ready", 64'(inst_ready), 64'd1);
    check("rst async outputs", 64'({txn_valid, txn_last, busy, done, txn_alen, txn_bitaddr}), 64'd0);
    txn_ready = 1'b0;
    @(negedge clk); rstnn = 1'b1;
    @(posedge clk); #1;
    run_inst(32'h7000, 16'h40, 8'd1, 12'd5, 100, "post-reset");

    // Randomized instructions against the reference model.
    for (int k = 0; k < 25; k++) begin
      logic [31:0] a;
      logic [15:0] s;
      a = $urandom;
      if ($urandom_range(1) == 1) a[11:0] = 12'hF00 | 12'($urandom_range(0, 255));
      s = ($urandom_range(3) == 0) ? 16'h0 : 16'($urandom_range(0, 16'hFFFF));
      run_inst(a, s, 8'($urandom_range(0, 3)), 12'($urandom_range(0, 40)),
               $urandom_range(30, 100), $sformatf("rand%0d", k));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
